// File: rtl/rle_symbolizer.sv
// rle_symbolizer
//
// Turns one 8x8 block of zig-zag ordered signed coefficients into a serial
// stream of JPEG-style run-length symbols (run, size, amplitude) for the
// Huffman code-table / bit-packer stage.
//
// Symbol order per block: one DC symbol, then AC symbols. Sixteen zeros in a
// row that are followed by a later nonzero coefficient become a ZRL (run 15,
// size 0). Trailing zeros collapse into a single EOB. A nonzero coef[63]
// carries sym_last itself, and no EOB follows it.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   in_valid   block available on A
//   in_ready   block stage can accept a block (high only in IDLE)
//   A          coefficient k at A[k*COEF_W +: COEF_W], index 0 = DC
//   sym_valid  symbol fields valid (registered)
//   sym_ready  downstream accepts the symbol
//   sym_run    zero run preceding the amplitude (0..15)
//   sym_size   magnitude category (0..8)
//   sym_amp    signed amplitude, raw coefficient value
//   sym_dc     symbol is the DC symbol
//   sym_last   final symbol of the block
//   done       one-cycle pulse after the last symbol handshake
module rle_symbolizer #(
    parameter int COEF_W = 8,
    parameter int NCOEF  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NCOEF*COEF_W-1:0]   A,
    output logic                      sym_valid,
    input  logic                      sym_ready,
    output logic [3:0]                sym_run,
    output logic [3:0]                sym_size,
    output logic [COEF_W-1:0]         sym_amp,
    output logic                      sym_dc,
    output logic                      sym_last,
    output logic                      done
);

    typedef enum logic [2:0] {IDLE, LOAD, SCAN, HOLD, FIN} state_t;

    state_t                    state_q, state_d;
    logic [NCOEF*COEF_W-1:0]   block_q, block_d;
    logic [6:0]                idx_q, idx_d;
    logic [5:0]                last_nz_q, last_nz_d;
    logic [3:0]                run_q, run_d;
    logic                      sym_valid_q, sym_valid_d;
    logic [3:0]                sym_run_q, sym_run_d;
    logic [3:0]                sym_size_q, sym_size_d;
    logic [COEF_W-1:0]         sym_amp_q, sym_amp_d;
    logic                      sym_dc_q, sym_dc_d;
    logic                      sym_last_q, sym_last_d;
    logic                      done_q, done_d;

    logic [5:0]                last_nz_c;
    logic [COEF_W-1:0]         coef_c;

    // Bit length of |v|; the magnitude is formed one bit wider so that the
    // most negative value does not overflow back to itself.
    function automatic logic [3:0] cat(input logic [COEF_W-1:0] v);
        logic [COEF_W:0] mag;
        logic [3:0]      c;
        mag = v[COEF_W-1] ? ({(COEF_W+1){1'b0}} - {v[COEF_W-1], v}) : {1'b0, v};
        c = '0;
        for (int i = 0; i <= COEF_W; i++) begin
            if (mag[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    // Highest nonzero AC index in the latched block, 0 when all AC are zero.
    always_comb begin
        last_nz_c = '0;
        for (int k = 1; k < NCOEF; k++) begin
            if (block_q[k*COEF_W +: COEF_W] != '0) last_nz_c = 6'(k);
        end
    end

    assign coef_c = block_q[int'(idx_q[5:0])*COEF_W +: COEF_W];

    // State and datapath registers; reset discards any block in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            block_q     <= '0;
            idx_q       <= '0;
            last_nz_q   <= '0;
            run_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_run_q   <= '0;
            sym_size_q  <= '0;
            sym_amp_q   <= '0;
            sym_dc_q    <= 1'b0;
            sym_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            idx_q       <= idx_d;
            last_nz_q   <= last_nz_d;
            run_q       <= run_d;
            sym_valid_q <= sym_valid_d;
            sym_run_q   <= sym_run_d;
            sym_size_q  <= sym_size_d;
            sym_amp_q   <= sym_amp_d;
            sym_dc_q    <= sym_dc_d;
            sym_last_q  <= sym_last_d;
            done_q      <= done_d;
        end
    end

    // Next-state logic. SCAN leaves only when a symbol has been loaded.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = LOAD;
            LOAD: state_d = HOLD;
            SCAN: begin
                if (idx_q > {1'b0, last_nz_q} || coef_c != '0 || run_q == 4'd15) begin
                    state_d = HOLD;
                end
            end
            HOLD: if (sym_ready) state_d = sym_last_q ? FIN : SCAN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath / output register inputs. Symbol fields only change when a
    // new symbol is loaded, so they stay stable for the whole HOLD.
    always_comb begin
        block_d     = block_q;
        idx_d       = idx_q;
        last_nz_d   = last_nz_q;
        run_d       = run_q;
        sym_valid_d = sym_valid_q;
        sym_run_d   = sym_run_q;
        sym_size_d  = sym_size_q;
        sym_amp_d   = sym_amp_q;
        sym_dc_d    = sym_dc_q;
        sym_last_d  = sym_last_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (in_valid) block_d = A;
            LOAD: begin
                last_nz_d   = last_nz_c;
                sym_run_d   = '0;
                sym_size_d  = cat(block_q[COEF_W-1:0]);
                sym_amp_d   = block_q[COEF_W-1:0];
                sym_dc_d    = 1'b1;
                sym_last_d  = 1'b0;
                sym_valid_d = 1'b1;
                idx_d       = 7'd1;
                run_d       = '0;
            end
            SCAN: begin
                if (idx_q > {1'b0, last_nz_q}) begin
                    sym_run_d   = '0;
                    sym_size_d  = '0;
                    sym_amp_d   = '0;
                    sym_dc_d    = 1'b0;
                    sym_last_d  = 1'b1;
                    sym_valid_d = 1'b1;
                end else if (coef_c != '0) begin
                    sym_run_d   = run_q;
                    sym_size_d  = cat(coef_c);
                    sym_amp_d   = coef_c;
                    sym_dc_d    = 1'b0;
                    sym_last_d  = (idx_q == 7'd63);
                    sym_valid_d = 1'b1;
                    run_d       = '0;
                    idx_d       = idx_q + 7'd1;
                end else if (run_q == 4'd15) begin
                    // This zero is the sixteenth of the run; ZRL absorbs it.
                    sym_run_d   = 4'd15;
                    sym_size_d  = '0;
                    sym_amp_d   = '0;
                    sym_dc_d    = 1'b0;
                    sym_last_d  = 1'b0;
                    sym_valid_d = 1'b1;
                    run_d       = '0;
                    idx_d       = idx_q + 7'd1;
                end else begin
                    run_d = run_q + 4'd1;
                    idx_d = idx_q + 7'd1;
                end
            end
            HOLD: begin
                if (sym_ready) begin
                    sym_valid_d = 1'b0;
                    done_d      = sym_last_q;
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign sym_valid = sym_valid_q;
    assign sym_run   = sym_run_q;
    assign sym_size  = sym_size_q;
    assign sym_amp   = sym_amp_q;
    assign sym_dc    = sym_dc_q;
    assign sym_last  = sym_last_q;
    assign done      = done_q;

endmodule

// File: tb/tb_rle_symbolizer.sv
// tb_rle_symbolizer
//
// Bench for rle_symbolizer. A reference model expands each driven block into
// its expected symbol list and pushes it onto a scoreboard queue; symbols are
// popped and compared as the DUT hands them over.
module tb_rle_symbolizer;

    typedef struct packed {
        logic [3:0] run;
        logic [3:0] size;
        logic [7:0] amp;
        logic       dc;
        logic       last;
    } sym_t;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] A;
    logic         sym_valid;
    logic         sym_ready;
    logic [3:0]   sym_run;
    logic [3:0]   sym_size;
    logic [7:0]   sym_amp;
    logic         sym_dc;
    logic         sym_last;
    logic         done;

    sym_t exp_q[$];
    int   tests_run;
    int   tests_failed;

    rle_symbolizer #(.COEF_W(8), .NCOEF(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_run   (sym_run),
        .sym_size  (sym_size),
        .sym_amp   (sym_amp),
        .sym_dc    (sym_dc),
        .sym_last  (sym_last),
        .done      (done)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so a stuck DUT still ends the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Magnitude category computed arithmetically.
    function automatic int model_cat(input int v);
        int a;
        int c;
        a = (v < 0) ? -v : v;
        c = 0;
        while (a > 0) begin
            c++;
            a = a >> 1;
        end
        return c;
    endfunction

    // Expand a block into its expected symbol list and queue it.
    task automatic model_push(input logic [511:0] blk);
        int   c[64];
        int   lastnz;
        int   zeros;
        sym_t s;
        for (int k = 0; k < 64; k++) c[k] = int'($signed(blk[k*8 +: 8]));
        lastnz = 0;
        for (int k = 1; k < 64; k++) if (c[k] != 0) lastnz = k;
        s = '{run: 4'd0, size: 4'(model_cat(c[0])), amp: 8'(c[0]), dc: 1'b1, last: 1'b0};
        exp_q.push_back(s);
        zeros = 0;
        for (int k = 1; k <= lastnz; k++) begin
            if (c[k] == 0) begin
                zeros++;
            end else begin
                while (zeros > 15) begin
                    exp_q.push_back('{run: 4'd15, size: 4'd0, amp: 8'd0, dc: 1'b0, last: 1'b0});
                    zeros -= 16;
                end
                s = '{run: 4'(zeros), size: 4'(model_cat(c[k])), amp: 8'(c[k]), dc: 1'b0, last: (k == 63)};
                exp_q.push_back(s);
                zeros = 0;
            end
        end
        if (lastnz < 63) exp_q.push_back('{run: 4'd0, size: 4'd0, amp: 8'd0, dc: 1'b0, last: 1'b1});
    endtask

    function automatic logic [511:0] make_block(input int v0, input int k1, input int v1,
                                                input int k2, input int v2);
        logic [511:0] b;
        b = '0;
        b[7:0] = 8'(v0);
        if (k1 > 0) b[k1*8 +: 8] = 8'(v1);
        if (k2 > 0) b[k2*8 +: 8] = 8'(v2);
        return b;
    endfunction

    // Hold in_valid until the block is taken; returns ok=0 on timeout.
    task automatic accept_block(input logic [511:0] blk, output bit ok);
        logic ready_prev;
        int   cyc;
        A        = blk;
        in_valid = 1'b1;
        ok       = 1'b0;
        cyc      = 0;
        while (!ok && cyc < 50) begin
            ready_prev = in_ready;
            @(posedge clock);
            #1;
            cyc++;
            ok = ready_prev;
        end
    endtask

    // Run one block through the DUT, checking every handed-over symbol
    // against the scoreboard, hold stability, busy in_ready and done.
    task automatic applyStimulus(input logic [511:0] blk, input bit rand_ready,
                                 input bit noise, output int nsyms);
        bit   ok;
        bit   first;
        bit   held_valid;
        bit   got_done;
        int   cyc;
        sym_t held;
        sym_t cur;
        sym_t e;
        nsyms = 0;
        model_push(blk);
        sym_ready = 1'b0;
        accept_block(blk, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL accept_timeout: in_ready got 0, expected 1 within 50 cycles");
            in_valid = 1'b0;
            exp_q.delete();
            return;
        end
        in_valid = noise ? 1'b1 : 1'b0;
        A = {16{$urandom}};
        tests_run++;
        if (in_ready !== 1'b0 || sym_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_state: in_ready=%b sym_valid=%b, expected 0 0", in_ready, sym_valid);
        end
        first      = 1'b1;
        held_valid = 1'b0;
        got_done   = 1'b0;
        cyc        = 0;
        while (!got_done && cyc < 2000) begin
            @(posedge clock);
            #1;
            cyc++;
            cur = {sym_run, sym_size, sym_amp, sym_dc, sym_last};
            if (noise) begin
                in_valid = 1'($urandom);
                A = {16{$urandom}};
            end
            if (first) begin
                first = 1'b0;
                tests_run++;
                if (sym_valid !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL first_latency: sym_valid=%b two cycles after accept, expected 1", sym_valid);
                end
            end
            tests_run++;
            if (in_ready !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL busy_in_ready: in_ready=%b while block in flight, expected 0", in_ready);
            end
            if (done === 1'b1) begin
                got_done  = 1'b1;
                in_valid  = 1'b0;
                sym_ready = 1'b0;
                tests_run++;
                if (sym_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL fin_valid: sym_valid=%b during done, expected 0", sym_valid);
                end
            end else begin
                if (held_valid) begin
                    tests_run++;
                    if (sym_valid !== 1'b1 || cur !== held) begin
                        tests_failed++;
                        $display("[TB] FAIL hold_stable: valid=%b fields=%h, expected valid=1 fields=%h",
                                 sym_valid, cur, held);
                    end
                end
                sym_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                if (sym_valid === 1'b1 && sym_ready) begin
                    held_valid = 1'b0;
                    nsyms++;
                    tests_run++;
                    if (exp_q.size() == 0) begin
                        tests_failed++;
                        $display("[TB] FAIL unexpected_symbol: got %h, expected no symbol", cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (cur !== e) begin
                            tests_failed++;
                            $display("[TB] FAIL symbol_%0d: got run=%0d size=%0d amp=%0d dc=%b last=%b, expected run=%0d size=%0d amp=%0d dc=%b last=%b",
                                     nsyms, cur.run, cur.size, $signed(cur.amp), cur.dc, cur.last,
                                     e.run, e.size, $signed(e.amp), e.dc, e.last);
                        end
                    end
                end else if (sym_valid === 1'b1) begin
                    held_valid = 1'b1;
                    held       = cur;
                end else begin
                    held_valid = 1'b0;
                end
            end
        end
        tests_run++;
        if (!got_done) begin
            tests_failed++;
            $display("[TB] FAIL done_timeout: done got 0, expected a pulse within 2000 cycles");
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL missing_symbols: %0d symbols outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clock);
        #1;
        tests_run++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL after_done: done=%b in_ready=%b, expected 0 1", done, in_ready);
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int expected);
        tests_run++;
        if (got != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, expected);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        sym_ready = 1'b0;
        A         = '0;
        #3;
        tests_run++;
        if (in_ready !== 1'b1 || sym_valid !== 1'b0 || sym_run !== 4'd0 || sym_size !== 4'd0 ||
            sym_amp !== 8'd0 || sym_dc !== 1'b0 || sym_last !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_state: in_ready=%b valid=%b run=%0d size=%0d amp=%0d dc=%b last=%b done=%b, expected 1 and all else 0",
                     in_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last, done);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_all_zero();
        int n;
        applyStimulus('0, 1'b0, 1'b0, n);
        checkOutput("all_zero_count", n, 2);
    endtask

    task automatic test_mixed();
        int n;
        applyStimulus(make_block(-6, 1, 3, 5, -1), 1'b0, 1'b0, n);
        checkOutput("mixed_count", n, 4);
    endtask

    task automatic test_zrl();
        int n;
        applyStimulus(make_block(1, 20, 5, 0, 0), 1'b0, 1'b0, n);
        checkOutput("zrl_count", n, 4);
    endtask

    task automatic test_coef63();
        int n;
        applyStimulus(make_block(0, 63, -128, 0, 0), 1'b0, 1'b0, n);
        checkOutput("coef63_count", n, 5);
    endtask

    task automatic test_back_to_back();
        int n;
        applyStimulus(make_block(-6, 1, 3, 5, -1), 1'b1, 1'b1, n);
        checkOutput("b2b_first_count", n, 4);
        applyStimulus(make_block(-6, 1, 3, 5, -1), 1'b1, 1'b0, n);
        checkOutput("b2b_second_count", n, 4);
    endtask

    task automatic test_random_blocks();
        int           n;
        logic [511:0] b;
        for (int t = 0; t < 6; t++) begin
            b = '0;
            for (int k = 0; k < 64; k++) begin
                if ($urandom_range(0, 5) == 0) b[k*8 +: 8] = 8'($urandom);
            end
            applyStimulus(b, 1'b1, 1'b0, n);
        end
    endtask

    // Abort the ZRL block with reset while the ZRL is held, then check the
    // next block comes out clean.
    task automatic test_reset_abort();
        bit   ok;
        bit   found;
        int   cyc;
        int   n;
        sym_t cur;
        sym_t e;
        model_push(make_block(1, 20, 5, 0, 0));
        sym_ready = 1'b0;
        accept_block(make_block(1, 20, 5, 0, 0), ok);
        in_valid  = 1'b0;
        sym_ready = 1'b1;
        found     = 1'b0;
        cyc       = 0;
        while (ok && !found && cyc < 200) begin
            @(posedge clock);
            #1;
            cyc++;
            cur = {sym_run, sym_size, sym_amp, sym_dc, sym_last};
            if (sym_valid === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (cur !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL abort_symbol: got %h, expected %h", cur, e);
                end
                if (!e.dc) begin
                    found     = 1'b1;
                    sym_ready = 1'b0;
                end
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("[TB] FAIL abort_zrl_seen: ZRL got 0, expected 1");
        end
        #2;
        reset = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || sym_valid !== 1'b0 || sym_run !== 4'd0 || sym_size !== 4'd0 ||
            sym_amp !== 8'd0 || sym_dc !== 1'b0 || sym_last !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: in_ready=%b valid=%b run=%0d size=%0d amp=%0d dc=%b last=%b done=%b, expected 1 and all else 0",
                     in_ready, sym_valid, sym_run, sym_size, sym_amp, sym_dc, sym_last, done);
        end
        exp_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        applyStimulus('0, 1'b0, 1'b0, n);
        checkOutput("post_reset_count", n, 2);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_all_zero();
        test_mixed();
        test_zrl();
        test_coef63();
        test_back_to_back();
        test_random_blocks();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
